// File: rtl/iic_arb_pkg.sv
// Shared types for the two-port EEPROM access arbiter: FSM states, rw encoding,
// captured request fields and a constant helper for sizing the shared counter.
package iic_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    WR_WAIT = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/iic_arb_timer.sv
// Loadable saturating down-counter shared by the tWR hold-off and the watchdog.
module iic_arb_timer #(
  parameter int W = 8
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)             cnt_d = load_val;
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/iic_arbiter.sv
// Round-robin arbiter/sequencer for two byte-level EEPROM requesters in front of
// the iic master. Define IIC_ARB_TIMEOUT_EN to enable the completion watchdog.
module iic_arbiter
  import iic_arb_pkg::*;
#(
  parameter int   TWR_CYCLES     = 250_000,
  parameter int   TIMEOUT_CYCLES = 20_000,
  parameter logic ADDR_16        = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req0_valid,
  input  logic        req0_rw,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_rw,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        iic_wr_en,
  output logic        iic_rd_en,
  output logic [15:0] iic_word_add,
  output logic [7:0]  iic_wr_data,
  output logic        iic_add_bit,
  input  logic        iic_done,
  input  logic [7:0]  iic_rd_data
);

  localparam int CNT_MAX = max_int(TWR_CYCLES, TIMEOUT_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic       gnt_q, gnt_d;
  req_t       req_q, req_d;
  logic [7:0] rdata_q, rdata_d;
  logic       done0_q, done0_d, done1_q, done1_d;
  logic       wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic       tmr_load, tmr_zero;
  logic [CW-1:0] tmr_val;
`ifdef IIC_ARB_TIMEOUT_EN
  logic       err0_q, err0_d, err1_q, err1_d;
`endif

  // Ready is gated by reset so no handshake is reported that cannot be captured.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE && !sys_rst) begin
      req0_ready = req0_valid && (!req1_valid || last_q);
      req1_ready = req1_valid && (!req0_valid || !last_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef IIC_ARB_TIMEOUT_EN
    err0_d   = 1'b0;
    err1_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          req_d   = '{rw: req0_rw, addr: req0_addr, wdata: req0_wdata};
          gnt_d   = 1'b0;
          last_d  = 1'b0;
          state_d = ISSUE;
          rd_en_d = (req0_rw == RW_READ);
          wr_en_d = (req0_rw == RW_WRITE);
        end else if (req1_ready) begin
          req_d   = '{rw: req1_rw, addr: req1_addr, wdata: req1_wdata};
          gnt_d   = 1'b1;
          last_d  = 1'b1;
          state_d = ISSUE;
          rd_en_d = (req1_rw == RW_READ);
          wr_en_d = (req1_rw == RW_WRITE);
        end
      end
      ISSUE: begin
        state_d = BUSY;
`ifdef IIC_ARB_TIMEOUT_EN
        tmr_load = 1'b1;
        tmr_val  = CW'(TIMEOUT_CYCLES - 1);
`endif
      end
      BUSY: begin
        if (iic_done) begin
          done0_d = !gnt_q;
          done1_d = gnt_q;
          if (req_q.rw == RW_READ) begin
            rdata_d = iic_rd_data;
            state_d = IDLE;
          end else begin
            state_d  = WR_WAIT;
            tmr_load = 1'b1;
            tmr_val  = CW'(TWR_CYCLES - 1);
          end
        end
`ifdef IIC_ARB_TIMEOUT_EN
        // Bus state is unknown after an abort, so always take the write hold-off.
        else if (tmr_zero) begin
          done0_d  = !gnt_q;
          done1_d  = gnt_q;
          err0_d   = !gnt_q;
          err1_d   = gnt_q;
          state_d  = WR_WAIT;
          tmr_load = 1'b1;
          tmr_val  = CW'(TWR_CYCLES - 1);
        end
`endif
      end
      WR_WAIT: begin
        if (tmr_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      req_q   <= '0;
      rdata_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
    end
  end

`ifdef IIC_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      err0_q <= err0_d;
      err1_q <= err1_d;
    end
  end
  assign req0_err = err0_q;
  assign req1_err = err1_q;
`else
  assign req0_err = 1'b0;
  assign req1_err = 1'b0;
`endif

  iic_arb_timer #(.W(CW)) u_timer (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (),
    .zero     (tmr_zero)
  );

  assign req0_done    = done0_q;
  assign req1_done    = done1_q;
  assign rdata        = rdata_q;
  assign busy         = (state_q != IDLE);
  assign iic_wr_en    = wr_en_q;
  assign iic_rd_en    = rd_en_q;
  assign iic_word_add = req_q.addr;
  assign iic_wr_data  = req_q.wdata;
  assign iic_add_bit  = ADDR_16;

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter with TWR_CYCLES=50 and TIMEOUT_CYCLES=30.
module tb_iic_arbiter;

  localparam int TWR = 50;
  localparam int TMO = 30;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        req0_valid = 1'b0, req0_rw = 1'b0;
  logic [15:0] req0_addr = '0;
  logic [7:0]  req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_rw = 1'b0;
  logic [15:0] req1_addr = '0;
  logic [7:0]  req1_wdata = '0;
  logic        req0_ready, req0_done, req0_err;
  logic        req1_ready, req1_done, req1_err;
  logic [7:0]  rdata;
  logic        busy, iic_wr_en, iic_rd_en, iic_add_bit;
  logic [15:0] iic_word_add;
  logic [7:0]  iic_wr_data;
  logic        iic_done = 1'b0;
  logic [7:0]  iic_rd_data = '0;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  iic_arbiter #(.TWR_CYCLES(TWR), .TIMEOUT_CYCLES(TMO), .ADDR_16(1'b1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
    .rdata(rdata), .busy(busy), .iic_wr_en(iic_wr_en), .iic_rd_en(iic_rd_en),
    .iic_word_add(iic_word_add), .iic_wr_data(iic_wr_data), .iic_add_bit(iic_add_bit),
    .iic_done(iic_done), .iic_rd_data(iic_rd_data)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; iic_done = 0;
    sys_rst = 1;
    step(2);
    sys_rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if ({iic_wr_en, iic_rd_en} !== 2'b00) begin bad++; $display("FAIL rst_en: got %b want 00", {iic_wr_en, iic_rd_en}); end
    total++; if ({req0_done, req1_done, req0_err, req1_err} !== 4'b0) begin bad++; $display("FAIL rst_done: got %b want 0000", {req0_done, req1_done, req0_err, req1_err}); end
    total++; if ({rdata, iic_word_add, iic_wr_data} !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", {rdata, iic_word_add, iic_wr_data}); end
    total++; if (iic_add_bit !== 1'b1) begin bad++; $display("FAIL rst_add_bit: got %b want 1", iic_add_bit); end
  endtask

  task automatic test_single_write();
    do_reset();
    req0_valid = 1; req0_rw = 0; req0_addr = 16'h0000; req0_wdata = 8'h55;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL wr_ready: got %b want 1", req0_ready); end
    step();
    req0_valid = 0;
    total++; if ({iic_wr_en, iic_rd_en} !== 2'b10) begin bad++; $display("FAIL wr_pulse: got %b want 10", {iic_wr_en, iic_rd_en}); end
    total++; if (iic_wr_data !== 8'h55) begin bad++; $display("FAIL wr_data: got %h want 55", iic_wr_data); end
    step();
    total++; if (iic_wr_en !== 1'b0) begin bad++; $display("FAIL wr_pulse_len: got %b want 0", iic_wr_en); end
    step(99);
    iic_done = 1;
    step();
    iic_done = 0;
    total++; if ({req0_done, req0_err, req1_done} !== 3'b100) begin bad++; $display("FAIL wr_done: got %b want 100", {req0_done, req0_err, req1_done}); end
    step(TWR - 1);
    total++; if (busy !== 1'b1 || req0_done !== 1'b0) begin bad++; $display("FAIL wr_twr_hold: got busy=%b done=%b want 1/0", busy, req0_done); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_twr_release: got %b want 0", busy); end
  endtask

  task automatic finish_read(input logic [7:0] d);
    step();
    iic_done = 1; iic_rd_data = d;
    step();
    iic_done = 0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req0_valid = 1; req0_rw = 1; req0_addr = 16'h0001;
    req1_valid = 1; req1_rw = 1; req1_addr = 16'h0002;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL tie1_ready: got %b want 10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 0;
    total++; if (iic_rd_en !== 1'b1 || iic_word_add !== 16'h0001) begin bad++; $display("FAIL tie1_issue: got rd=%b a=%h want 1/0001", iic_rd_en, iic_word_add); end
    finish_read(8'h11);
    #1;
    total++; if ({req0_done, req1_ready, rdata} !== {2'b11, 8'h11}) begin bad++; $display("FAIL tie1_done: got %b/%b/%h want 1/1/11", req0_done, req1_ready, rdata); end
    step();
    req1_valid = 0;
    total++; if (iic_rd_en !== 1'b1 || iic_word_add !== 16'h0002) begin bad++; $display("FAIL tie2_issue: got rd=%b a=%h want 1/0002", iic_rd_en, iic_word_add); end
    finish_read(8'h22);
    req0_valid = 1; req1_valid = 1;
    #1;
    total++; if ({req1_done, req0_ready, req1_ready} !== 3'b110) begin bad++; $display("FAIL tie3_ready: got %b want 110", {req1_done, req0_ready, req1_ready}); end
    step();
    req0_valid = 0;
    finish_read(8'h33);
    req0_valid = 1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL tie4_ready: got %b want 01", {req0_ready, req1_ready}); end
    step();
    req0_valid = 0; req1_valid = 0;
    finish_read(8'h44);
  endtask

  task automatic test_read_data();
    do_reset();
    req1_valid = 1; req1_rw = 1; req1_addr = 16'h0010;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL rd_ready: got %b want 1", req1_ready); end
    step();
    req1_valid = 0;
    total++; if (iic_word_add !== 16'h0010) begin bad++; $display("FAIL rd_addr: got %h want 0010", iic_word_add); end
    finish_read(8'hA5);
    total++; if ({rdata, req1_done, req0_done, req1_err} !== {8'hA5, 3'b100}) begin bad++; $display("FAIL rd_data: got %h/%b%b%b want a5/100", rdata, req1_done, req0_done, req1_err); end
    step();
    total++; if ({req1_done, busy, rdata} !== {2'b00, 8'hA5}) begin bad++; $display("FAIL rd_after: got %b%b/%h want 00/a5", req1_done, busy, rdata); end
  endtask

  task automatic test_write_guard();
    int n;
    do_reset();
    req0_valid = 1; req0_rw = 0; req0_addr = 16'h0100; req0_wdata = 8'h3C;
    step();
    req0_valid = 0;
    req1_valid = 1; req1_rw = 1; req1_addr = 16'h0200;
    #1;
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL guard_issue_ready: got %b want 0", req1_ready); end
    step();
    iic_done = 1;
    step();
    iic_done = 0;
    #1;
    total++; if ({req0_done, req1_ready} !== 2'b10) begin bad++; $display("FAIL guard_done: got %b want 10", {req0_done, req1_ready}); end
    n = 0;
    while (req1_ready !== 1'b1 && n < 200) begin step(); n++; end
    total++; if (n !== TWR) begin bad++; $display("FAIL guard_gap: got %0d want %0d", n, TWR); end
    step();
    req1_valid = 0;
    finish_read(8'h5A);
  endtask

  task automatic test_reset_busy();
    do_reset();
    req0_valid = 1; req0_rw = 1; req0_addr = 16'h0ABC;
    step();
    req0_valid = 0;
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rb_busy: got %b want 1", busy); end
    sys_rst = 1;
    step();
    sys_rst = 0;
    total++; if ({busy, iic_rd_en, req0_done, iic_word_add} !== 19'h0) begin bad++; $display("FAIL rb_outs: got %b%b%b/%h want 000/0000", busy, iic_rd_en, req0_done, iic_word_add); end
    iic_done = 1; iic_rd_data = 8'hEE;
    step();
    iic_done = 0;
    total++; if ({req0_done, req1_done, busy, rdata} !== 11'h0) begin bad++; $display("FAIL rb_late_done: got %b%b%b/%h want 000/00", req0_done, req1_done, busy, rdata); end
  endtask

`ifdef IIC_ARB_TIMEOUT_EN
  task automatic test_watchdog();
    do_reset();
    req0_valid = 1; req0_rw = 1; req0_addr = 16'h0042;
    step();
    req0_valid = 0;
    total++; if (iic_rd_en !== 1'b1) begin bad++; $display("FAIL wd_issue: got %b want 1", iic_rd_en); end
    step(TMO);
    total++; if (req0_done !== 1'b0) begin bad++; $display("FAIL wd_early: got %b want 0", req0_done); end
    step();
    total++; if ({req0_done, req0_err, busy, rdata} !== {3'b111, 8'h00}) begin bad++; $display("FAIL wd_abort: got %b%b%b/%h want 111/00", req0_done, req0_err, busy, rdata); end
    step(TWR - 1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wd_wrwait: got %b want 1", busy); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wd_release: got %b want 0", busy); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_read_data();
    test_write_guard();
    test_reset_busy();
`ifdef IIC_ARB_TIMEOUT_EN
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
